// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - W stage: load extraction, result select, W->D bypass, instret counter, retire trace
module writeback_stage #(
  parameter logic [63:0] INSTRET_RESET = 64'h0,
  parameter bit          TRACE_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        ValidW,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcW,
  input  logic [2:0]  LoadOpW,
  input  logic [4:0]  RdW,
  input  logic [31:0] AluResultW,
  input  logic [31:0] PCPlus4W,
  input  logic [31:0] ReadDataW,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [31:0] RD1RawD,
  input  logic [31:0] RD2RawD,
  input  logic        InstretWe,
  input  logic        InstretWrHi,
  input  logic [31:0] InstretWrData,
  output logic [31:0] ResultW,
  output logic        RfWe,
  output logic [4:0]  RfAddr,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [63:0] Instret,
  output logic        RetireValid,
  output logic [31:0] RetirePC,
  output logic [4:0]  RetireRd,
  output logic [31:0] RetireData
);

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Load ops use the RISC-V funct3 encoding
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_result;
  logic        w_rf_we;
  logic [63:0] r_instret;
  logic [63:0] w_instret_inc;

  always_comb begin
    w_byte = 8'h00;
    case (AluResultW[1:0])
      2'd0: w_byte = ReadDataW[7:0];
      2'd1: w_byte = ReadDataW[15:8];
      2'd2: w_byte = ReadDataW[23:16];
      2'd3: w_byte = ReadDataW[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  // Misaligned halves fall back to offset[1]; no trap is raised in this stage
  assign w_half = AluResultW[1] ? ReadDataW[31:16] : ReadDataW[15:0];

  always_comb begin
    w_load = ReadDataW;
    case (LoadOpW)
      LD_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      LD_LH:   w_load = {{16{w_half[15]}}, w_half};
      LD_LW:   w_load = ReadDataW;
      LD_LBU:  w_load = {24'h0, w_byte};
      LD_LHU:  w_load = {16'h0, w_half};
      default: w_load = ReadDataW;
    endcase
  end

  always_comb begin
    w_result = AluResultW;
    case (ResultSrcW)
      RES_ALU: w_result = AluResultW;
      RES_MEM: w_result = w_load;
      RES_PC4: w_result = PCPlus4W;
      default: w_result = AluResultW;
    endcase
  end

  assign w_rf_we = RegWriteW & ValidW & (RdW != 5'd0);

  assign ResultW = w_result;
  assign RfWe    = w_rf_we;
  assign RfAddr  = RdW;

  // w_rf_we already excludes x0, so a zero source index never bypasses
  assign RD1D = (w_rf_we && (Rs1D == RdW)) ? w_result : RD1RawD;
  assign RD2D = (w_rf_we && (Rs2D == RdW)) ? w_result : RD2RawD;

  assign w_instret_inc = r_instret + 64'd1;

  // A CSR write wins over the retire increment so software sees the exact value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instret <= INSTRET_RESET;
    end else if (InstretWe) begin
      if (InstretWrHi) begin
        r_instret[63:32] <= InstretWrData;
      end else begin
        r_instret[31:0] <= InstretWrData;
      end
    end else if (ValidW && !Stall) begin
      r_instret <= w_instret_inc;
    end
  end

  assign Instret = r_instret;

  generate
    if (TRACE_EN) begin : g_trace
      logic        r_ret_valid;
      logic [31:0] r_ret_pc;
      logic [4:0]  r_ret_rd;
      logic [31:0] r_ret_data;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_ret_valid <= 1'b0;
          r_ret_pc    <= 32'h0;
          r_ret_rd    <= 5'd0;
          r_ret_data  <= 32'h0;
        end else if (Stall) begin
          r_ret_valid <= 1'b0;
        end else begin
          r_ret_valid <= ValidW;
          r_ret_pc    <= PCPlus4W - 32'd4;
          r_ret_rd    <= w_rf_we ? RdW : 5'd0;
          r_ret_data  <= w_rf_we ? w_result : 32'h0;
        end
      end

      assign RetireValid = r_ret_valid;
      assign RetirePC    = r_ret_pc;
      assign RetireRd    = r_ret_rd;
      assign RetireData  = r_ret_data;
    end else begin : g_no_trace
      assign RetireValid = 1'b0;
      assign RetirePC    = 32'h0;
      assign RetireRd    = 5'd0;
      assign RetireData  = 32'h0;
    end
  endgenerate

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage
module tb_writeback_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] d;
  } trace_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall, ValidW, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [2:0]  LoadOpW;
  logic [4:0]  RdW, Rs1D, Rs2D;
  logic [31:0] AluResultW, PCPlus4W, ReadDataW, RD1RawD, RD2RawD;
  logic        InstretWe, InstretWrHi;
  logic [31:0] InstretWrData;
  logic [31:0] ResultW, RD1D, RD2D, RetirePC, RetireData;
  logic        RfWe, RetireValid;
  logic [4:0]  RfAddr, RetireRd;
  logic [63:0] Instret;

  int          n_cmp = 0;
  int          n_err = 0;
  trace_t      sb[$];
  trace_t      t_last;
  logic [63:0] exp_instret;

  writeback_stage #(.INSTRET_RESET(64'h0), .TRACE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .LoadOpW(LoadOpW), .RdW(RdW), .AluResultW(AluResultW),
    .PCPlus4W(PCPlus4W), .ReadDataW(ReadDataW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RD1RawD(RD1RawD), .RD2RawD(RD2RawD), .InstretWe(InstretWe), .InstretWrHi(InstretWrHi),
    .InstretWrData(InstretWrData), .ResultW(ResultW), .RfWe(RfWe), .RfAddr(RfAddr),
    .RD1D(RD1D), .RD2D(RD2D), .Instret(Instret), .RetireValid(RetireValid),
    .RetirePC(RetirePC), .RetireRd(RetireRd), .RetireData(RetireData)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_result();
    logic [31:0] sb8, sh16;
    sb8  = ReadDataW >> (8 * AluResultW[1:0]);
    sh16 = ReadDataW >> (16 * AluResultW[1]);
    if (ResultSrcW == 2'b10) return PCPlus4W;
    if (ResultSrcW != 2'b01) return AluResultW;
    case (LoadOpW)
      3'b000:  return {{24{sb8[7]}}, sb8[7:0]};
      3'b001:  return {{16{sh16[15]}}, sh16[15:0]};
      3'b100:  return {24'h0, sb8[7:0]};
      3'b101:  return {16'h0, sh16[15:0]};
      default: return ReadDataW;
    endcase
  endfunction

  // Called at posedge+1: checks combinational outputs, then the trace/counter after the edge
  task automatic step();
    trace_t      e;
    logic [31:0] r;
    logic        we;
    r  = model_result();
    we = RegWriteW & ValidW & (RdW != 5'd0);
    #1;
    check("result", ResultW, r);
    check("rfwe", RfWe, we);
    check("rfaddr", RfAddr, RdW);
    check("rd1", RD1D, (we && Rs1D == RdW) ? r : RD1RawD);
    check("rd2", RD2D, (we && Rs2D == RdW) ? r : RD2RawD);
    if (!Stall) begin
      t_last = '{v: ValidW, pc: PCPlus4W - 32'd4, rd: we ? RdW : 5'd0, d: we ? r : 32'h0};
      e = t_last;
    end else begin
      e = t_last;
      e.v = 1'b0;
    end
    sb.push_back(e);
    if (InstretWe) begin
      if (InstretWrHi) exp_instret[63:32] = InstretWrData;
      else             exp_instret[31:0]  = InstretWrData;
    end else if (ValidW && !Stall) begin
      exp_instret = exp_instret + 64'd1;
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    check("ret_valid", RetireValid, e.v);
    check("ret_pc", RetirePC, e.pc);
    check("ret_rd", RetireRd, e.rd);
    check("ret_data", RetireData, e.d);
    check("instret", Instret, exp_instret);
  endtask

  task automatic set_slot(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] lop,
                          input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4,
                          input logic [31:0] rdata);
    ValidW = v; RegWriteW = rw; ResultSrcW = src; LoadOpW = lop;
    RdW = rd; AluResultW = alu; PCPlus4W = pc4; ReadDataW = rdata;
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; InstretWe = 1'b0; InstretWrHi = 1'b0; InstretWrData = 32'h0;
    set_slot(1'b0, 1'b0, 2'b00, 3'b010, 5'd0, 32'h0, 32'h4, 32'h0);
    Rs1D = 5'd0; Rs2D = 5'd0; RD1RawD = 32'h1111; RD2RawD = 32'h2222;
    exp_instret = 64'h0; t_last = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instret", Instret, 64'h0);
    check("rst_ret_valid", RetireValid, 1'b0);
    check("rst_ret_pc", RetirePC, 32'h0);
    check("rst_ret_data", RetireData, 32'h0);
    reset = 1'b0;

    // Load extraction
    set_slot(1'b1, 1'b1, 2'b01, 3'b000, 5'd5, 32'h1001, 32'h204, 32'h1234_80FF);
    step(); check("lb_const", ResultW, 32'hFFFF_FF80);
    LoadOpW = 3'b100;
    step(); check("lbu_const", ResultW, 32'h0000_0080);
    set_slot(1'b1, 1'b1, 2'b01, 3'b101, 5'd6, 32'h1002, 32'h208, 32'h1234_80FF);
    step(); check("lhu_const", ResultW, 32'h0000_1234);
    set_slot(1'b1, 1'b1, 2'b01, 3'b001, 5'd7, 32'h1003, 32'h20C, 32'h8765_4321);
    step(); check("lh_misal", ResultW, 32'hFFFF_8765);
    set_slot(1'b1, 1'b1, 2'b01, 3'b010, 5'd8, 32'h1003, 32'h210, 32'hCAFE_BABE);
    step(); check("lw_offset", ResultW, 32'hCAFE_BABE);
    for (int i = 0; i < 6; i++) begin
      set_slot(1'b1, 1'b1, 2'b01, (i % 2 == 0) ? 3'b000 : 3'b001, 5'(i + 9), 32'($urandom),
               32'h300 + 32'(4 * i), $urandom);
      Rs2D = 5'(i + 9); RD2RawD = $urandom;
      step();
    end

    // PC+4 result with bypass, then x0 destination
    Rs1D = 5'd1; RD1RawD = 32'hDEAD; Rs2D = 5'd0;
    set_slot(1'b1, 1'b1, 2'b10, 3'b010, 5'd1, 32'h55, 32'h100, 32'h0);
    step(); check("pc4_rd1", RD1D, 32'h100); check("pc4_rfwe", RfWe, 1'b1);
    RdW = 5'd0; Rs1D = 5'd0;
    step(); check("x0_rfwe", RfWe, 1'b0); check("x0_rd1", RD1D, 32'hDEAD);

    // Counter cleared by CSR, then stall pattern
    set_slot(1'b0, 1'b0, 2'b00, 3'b010, 5'd0, 32'h0, 32'h4, 32'h0);
    InstretWe = 1'b1; InstretWrHi = 1'b0; InstretWrData = 32'h0; step();
    InstretWrHi = 1'b1; step();
    InstretWe = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_slot(1'b1, 1'b1, 2'b00, 3'b010, 5'd2, 32'(i + 100), 32'h400 + 32'(4 * i), 32'h0);
      Stall = (i == 3);
      step();
    end
    Stall = 1'b0;
    check("stall_count", Instret, 64'd4);

    // Carry across halves, CSR high write overriding a retire, full wrap
    set_slot(1'b0, 1'b0, 2'b00, 3'b010, 5'd0, 32'h0, 32'h4, 32'h0);
    InstretWe = 1'b1; InstretWrHi = 1'b0; InstretWrData = 32'hFFFF_FFFF; step();
    InstretWe = 1'b0; ValidW = 1'b1; step();
    check("carry", Instret, 64'h0000_0001_0000_0000);
    InstretWe = 1'b1; InstretWrHi = 1'b1; InstretWrData = 32'hABCD; step();
    check("csr_hi_over", Instret, 64'h0000_ABCD_0000_0000);
    ValidW = 1'b0; InstretWrData = 32'hFFFF_FFFF; step();
    InstretWrHi = 1'b0; step();
    InstretWe = 1'b0; ValidW = 1'b1; step();
    check("wrap", Instret, 64'h0);

    // Bubble with RegWriteW high
    set_slot(1'b0, 1'b1, 2'b00, 3'b010, 5'd3, 32'h77, 32'h500, 32'h0);
    step(); check("bubble_rfwe", RfWe, 1'b0); check("bubble_ret", RetireValid, 1'b0);

    // Asynchronous reset mid-cycle
    set_slot(1'b1, 1'b1, 2'b00, 3'b010, 5'd4, 32'h99, 32'h600, 32'h0);
    step(); step();
    #3 reset = 1'b1;
    #1;
    check("arst_instret", Instret, 64'h0);
    check("arst_ret_valid", RetireValid, 1'b0);
    check("arst_ret_pc", RetirePC, 32'h0);
    exp_instret = 64'h0; t_last = '0; sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    step();
    check("post_rst", Instret, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final stage of the kianv 5-stage pipeline; consumes the W-side registers produced by the memory stage.
- Performs load extraction and sign/zero extension from ReadDataW, and selects the result into the register-file write port.
- Provides combinational W->D bypass for same-cycle register reads.
- Maintains the 64-bit retired-instruction counter with CSR write access, and emits a registered one-cycle-delayed retire trace.

Parameters:
- INSTRET_RESET, 64'h0, reset value of the instret counter.
- TRACE_EN, 1, 1 = retire trace registers present; 0 = trace outputs tied to 0.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- Stall  in  1  pipeline stall; freezes counter and trace capture
- ValidW  in  1  W holds a real instruction (not a bubble/flushed slot)
- RegWriteW  in  1  write-back enable from memory stage
- ResultSrcW  in  ResultSrc_t  result select: ALU, memory, PC+4
- LoadOpW  in  LoadOp_t  LB/LH/LW/LBU/LHU
- RdW  in  5  destination register
- AluResultW  in  32  ALU result; bits [1:0] give the load byte offset
- PCPlus4W  in  32  PC+4 of the W instruction
- ReadDataW  in  32  raw 32-bit memory word
- Rs1D, Rs2D  in  5 each  decode-stage source indices
- RD1RawD, RD2RawD  in  32 each  raw register-file read data
- InstretWe  in  1  CSR write strobe to instret
- InstretWrHi  in  1  0 = write minstret[31:0]; 1 = write minstret[63:32]
- InstretWrData  in  32  CSR write data
- ResultW  out  32  selected write-back value
- RfWe  out  1  register-file write enable
- RfAddr  out  5  register-file write address (= RdW)
- RD1D, RD2D  out  32 each  bypassed decode operands
- Instret  out  64  retired-instruction counter
- RetireValid  out  1  registered retire strobe
- RetirePC  out  32  registered PC of the retired instruction
- RetireRd  out  5  registered destination (0 if no write)
- RetireData  out  32  registered write value (0 if no write)

Behaviour:
- Load extraction (combinational), offset = AluResultW[1:0]:
  - LB/LBU select byte[offset]; LH/LHU select half[offset[1]].
  - Signed ops sign-extend; unsigned ops zero-extend.
  - LW passes ReadDataW unchanged, ignoring the offset.
  - Misaligned half/word: use offset[1] for half; word ignores offset. No trap is raised here.
- ResultW (combinational): ALU -> AluResultW, memory -> extracted load, PC+4 -> PCPlus4W.
- RfWe = RegWriteW & ValidW & (RdW != 0). RfAddr = RdW. x0 is never written.
- Bypass: RD1D = ResultW if RfWe && Rs1D == RdW, else RD1RawD. RD2D uses the same rule with Rs2D/RD2RawD. Rs = 0 always returns RD*RawD.
- Instret (registered, async reset to INSTRET_RESET):
  - Increments by 1 on each clk edge with ValidW & !Stall.
  - Wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0; carry propagates across the 32-bit halves in the same cycle.
  - InstretWe writes the selected half on that edge. The CSR write overrides the increment for that cycle, so the written value is exact and the other half is held.
- Retire trace (registered, async reset: all outputs 0):
  - On an edge with !Stall: RetireValid <= ValidW; RetirePC <= PCPlus4W - 4; RetireRd <= RfWe ? RdW : 0; RetireData <= RfWe ? ResultW : 0.
  - On an edge with Stall: RetireValid <= 0, other trace outputs hold.
  - Latency is 1 cycle from the W slot to the trace outputs.
- Reset asserted mid-operation clears the counter and trace immediately (asynchronous). Combinational outputs keep following their inputs.
- Stall does not gate RfWe, because the register file write is idempotent for a frozen W slot. Stall only gates the counter and trace.

Test Plan:
- LB, AluResultW=0x1001, ReadDataW=0x1234_80FF -> ResultW=0xFFFF_FF80; same access with LBU -> 0x0000_0080; LHU at offset 2 -> 0x0000_1234.
- ResultSrc PC+4, PCPlus4W=0x100, RdW=1, RegWriteW=1, ValidW=1, Rs1D=1, RD1RawD=0xDEAD -> RD1D=0x100, RfWe=1; repeat with RdW=0 -> RfWe=0, RD1D=RD1RawD.
- 5 valid cycles with Stall low on cycles 2-3 and high on cycle 4 -> Instret=4; RetireValid pulses only for the non-stalled slots, with RetirePC=PCPlus4W-4.
- Set Instret low half to 0xFFFF_FFFF via CSR, then one valid retire -> Instret=0x0000_0001_0000_0000; then CSR write of the high half with a simultaneous retire -> high = written value, low unchanged.
- Assert reset asynchronously between clock edges during valid retires -> Instret=INSTRET_RESET and RetireValid=0 immediately; counting resumes from 0 on the first valid edge after release.
- ValidW=0 with RegWriteW=1 (bubble) -> RfWe=0, no increment, RetireValid=0 next cycle.
